// File: rtl/t05_stage_sequencer.sv
// ============================================================================
// t05_stage_sequencer
// ----------------------------------------------------------------------------
// Top-level controller for the team_05 Huffman compression pipeline. Walks the
// stages (histogram, least-frequency sort, tree build, codebook/path
// generation, translation) by broadcasting the active stage number on
// en_state and advancing when that stage reports completion on fin_state.
// Every stage is guarded by a watchdog. Protocol violations are latched into
// sticky error fields. Per-stage and per-run cycle counts are kept for
// bring-up and profiling.
//
// Parameters:
//   STAGE_TIMEOUT - maximum cycles a stage may hold en_state (2 .. 2^32-1)
//   LAST_STAGE    - number of the final stage; its completion code is
//                   LAST_STAGE+1
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous reset, active-high
//   start        in   request a run (honoured only in IDLE or ERROR)
//   abort        in   cancel the run, return to IDLE without done
//   fin_state    in   [3:0] completion code from the active stage (k -> k+1)
//   en_state     out  [3:0] active-stage select, 0 = no stage enabled
//   busy         out  high while a stage is enabled
//   done         out  one-cycle pulse when the last stage completes
//   error        out  sticky error flag
//   err_stage    out  [3:0] stage active when the error was raised
//   err_code     out  [1:0] 01 = watchdog timeout, 10 = illegal fin_state
//   stage_cycles out  [31:0] cycle count of the most recently completed stage
//   total_cycles out  [31:0] busy cycles of the current/last run, saturating
// ============================================================================
module t05_stage_sequencer #(
    parameter logic [31:0] STAGE_TIMEOUT = 32'd1_048_576,
    parameter logic [3:0]  LAST_STAGE    = 4'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  fin_state,
    output logic [3:0]  en_state,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  err_stage,
    output logic [1:0]  err_code,
    output logic [31:0] stage_cycles,
    output logic [31:0] total_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b01;
    localparam logic [1:0] CODE_ILLEGAL  = 2'b10;
    localparam logic [31:0] WATCHDOG_MAX = STAGE_TIMEOUT - 32'd1;

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [3:0]  en_nxt;
    logic        busy_nxt;
    logic        done_nxt;
    logic        error_nxt;
    logic [3:0]  err_stage_nxt;
    logic [1:0]  err_code_nxt;
    logic [31:0] stage_cycles_nxt;
    logic [31:0] total_nxt;

    logic [3:0]  expected_fin;
    logic [31:0] total_inc;

    // The active stage k signals completion with code k+1; any other non-zero
    // code while running is a protocol violation.
    assign expected_fin = en_state + 4'd1;

    // Run-length counter saturates rather than wrapping, so an overlong run
    // still reads as "very long" instead of a misleading small number.
    assign total_inc = (total_cycles == 32'hFFFF_FFFF) ? total_cycles
                                                        : total_cycles + 32'd1;

    // State and output registers. Every output is driven straight from a
    // flop so downstream stages never see combinational glitches on en_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 32'd0;
            en_state     <= 4'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_stage    <= 4'd0;
            err_code     <= CODE_NONE;
            stage_cycles <= 32'd0;
            total_cycles <= 32'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            en_state     <= en_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            error        <= error_nxt;
            err_stage    <= err_stage_nxt;
            err_code     <= err_code_nxt;
            stage_cycles <= stage_cycles_nxt;
            total_cycles <= total_nxt;
        end
    end

    // Next-state and next-output logic. Everything holds by default and done
    // defaults low so it can only ever be a single-cycle pulse.
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        en_nxt           = en_state;
        busy_nxt         = busy;
        done_nxt         = 1'b0;
        error_nxt        = error;
        err_stage_nxt    = err_stage;
        err_code_nxt     = err_code;
        stage_cycles_nxt = stage_cycles;
        total_nxt        = total_cycles;

        case (state)
            IDLE: begin
                // abort wins over a simultaneous start; fin_state is stale here
                if (start && !abort) begin
                    state_nxt        = RUN;
                    en_nxt           = 4'd1;
                    busy_nxt         = 1'b1;
                    cnt_nxt          = 32'd0;
                    stage_cycles_nxt = 32'd0;
                    total_nxt        = 32'd0;
                end
            end

            ERROR: begin
                // Leaving ERROR by either path wipes the diagnostic fields.
                if (abort) begin
                    state_nxt     = IDLE;
                    error_nxt     = 1'b0;
                    err_stage_nxt = 4'd0;
                    err_code_nxt  = CODE_NONE;
                end else if (start) begin
                    state_nxt        = RUN;
                    en_nxt           = 4'd1;
                    busy_nxt         = 1'b1;
                    cnt_nxt          = 32'd0;
                    stage_cycles_nxt = 32'd0;
                    total_nxt        = 32'd0;
                    error_nxt        = 1'b0;
                    err_stage_nxt    = 4'd0;
                    err_code_nxt     = CODE_NONE;
                end
            end

            RUN: begin
                if (abort) begin
                    // Cancel outright: counters freeze at their current values.
                    state_nxt = IDLE;
                    en_nxt    = 4'd0;
                    busy_nxt  = 1'b0;
                end else begin
                    total_nxt = total_inc;
                    if (fin_state == expected_fin) begin
                        // Checked before the watchdog so a finish on the very
                        // last allowed cycle still counts as success.
                        stage_cycles_nxt = cnt + 32'd1;
                        cnt_nxt          = 32'd0;
                        if (en_state == LAST_STAGE) begin
                            state_nxt = IDLE;
                            en_nxt    = 4'd0;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            en_nxt = en_state + 4'd1;
                        end
                    end else if (fin_state != 4'd0) begin
                        state_nxt     = ERROR;
                        en_nxt        = 4'd0;
                        busy_nxt      = 1'b0;
                        error_nxt     = 1'b1;
                        err_stage_nxt = en_state;
                        err_code_nxt  = CODE_ILLEGAL;
                    end else if (cnt == WATCHDOG_MAX) begin
                        // cnt counts from 0 in the first enabled cycle, so this
                        // fires at the end of the STAGE_TIMEOUT-th cycle.
                        state_nxt     = ERROR;
                        en_nxt        = 4'd0;
                        busy_nxt      = 1'b0;
                        error_nxt     = 1'b1;
                        err_stage_nxt = en_state;
                        err_code_nxt  = CODE_TIMEOUT;
                    end else begin
                        cnt_nxt = cnt + 32'd1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                en_nxt    = 4'd0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_t05_stage_sequencer.sv
// ============================================================================
// tb_t05_stage_sequencer
// ----------------------------------------------------------------------------
// Self-checking bench for t05_stage_sequencer (STAGE_TIMEOUT=16,
// LAST_STAGE=5). A table of per-cycle {inputs, expected outputs} records is
// built up front and replayed; each record's expectation is queued when its
// inputs are driven and compared once the following clock edge has updated
// the DUT. Hand-written sequences then cover the watchdog, ERROR exits and an
// asynchronous reset in the middle of stage 5.
// ============================================================================
module tb_t05_stage_sequencer;

    localparam logic [31:0] TIMEOUT = 32'd16;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [3:0]  fin_state;
    logic [3:0]  en_state;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  err_stage;
    logic [1:0]  err_code;
    logic [31:0] stage_cycles;
    logic [31:0] total_cycles;

    t05_stage_sequencer #(
        .STAGE_TIMEOUT (TIMEOUT),
        .LAST_STAGE    (4'd5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .fin_state    (fin_state),
        .en_state     (en_state),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_stage    (err_stage),
        .err_code     (err_code),
        .stage_cycles (stage_cycles),
        .total_cycles (total_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        abort;
        logic [3:0]  fin;
        logic [3:0]  en;
        logic        busy;
        logic        done;
        logic        error;
        logic [3:0]  est;
        logic [1:0]  ecode;
        logic [31:0] sc;
        logic [31:0] tot;
        string       name;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t table_q[$];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic st, input logic ab, input logic [3:0] fin,
                                input logic [3:0] en, input logic bsy, input logic dn,
                                input logic er, input logic [3:0] est, input logic [1:0] ec,
                                input logic [31:0] sc, input logic [31:0] tot,
                                input string nm);
        vec_t v;
        v.start = st;  v.abort = ab;  v.fin = fin;
        v.en = en;     v.busy = bsy;  v.done = dn;   v.error = er;
        v.est = est;   v.ecode = ec;  v.sc = sc;     v.tot = tot;
        v.name = nm;
        return v;
    endfunction

    task automatic check_output(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Drive one cycle of inputs (called at posedge+1), queue the expectation,
    // then compare after the next edge.
    task automatic apply_stimulus(input vec_t v);
        vec_t e;
        start     = v.start;
        abort     = v.abort;
        fin_state = v.fin;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_output({e.name, " ctrl{en,busy,done,err,est,code}"},
                     64'({en_state, busy, done, error, err_stage, err_code}),
                     64'({e.en, e.busy, e.done, e.error, e.est, e.ecode}));
        check_output({e.name, " counters{stage,total}"},
                     {stage_cycles, total_cycles}, {e.sc, e.tot});
    endtask

    // Safety net against a hung simulation.
    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int tot;
        logic [3:0] fin_v;

        rst = 1'b1; start = 1'b0; abort = 1'b0; fin_state = 4'd0;

        // ---- Scenario A: normal run, each stage finishes on its 3rd cycle ----
        table_q.push_back(mk(1, 0, 4'd0, 4'd1, 1, 0, 0, 4'd0, 2'b00, 0, 0, "A start"));
        tot = 0;
        for (int k = 1; k <= 5; k++) begin
            for (int c = 1; c <= 3; c++) begin
                tot++;
                fin_v = (c == 3) ? 4'(k + 1) : 4'd0;
                if (c < 3)
                    table_q.push_back(mk(0, 0, fin_v, 4'(k), 1, 0, 0, 4'd0, 2'b00,
                                         (k == 1) ? 32'd0 : 32'd3, 32'(tot), $sformatf("A s%0d c%0d", k, c)));
                else if (k < 5)
                    table_q.push_back(mk(0, 0, fin_v, 4'(k + 1), 1, 0, 0, 4'd0, 2'b00,
                                         32'd3, 32'(tot), $sformatf("A s%0d fin", k)));
                else
                    table_q.push_back(mk(0, 0, fin_v, 4'd0, 0, 1, 0, 4'd0, 2'b00,
                                         32'd3, 32'(tot), "A last fin done"));
            end
        end
        table_q.push_back(mk(0, 0, 4'd6, 4'd0, 0, 0, 0, 4'd0, 2'b00, 3, 15, "A idle stale fin"));
        table_q.push_back(mk(1, 1, 4'd0, 4'd0, 0, 0, 0, 4'd0, 2'b00, 3, 15, "idle start+abort"));

        // ---- Scenario B: illegal completion code in stage 2 ----
        table_q.push_back(mk(1, 0, 4'd0, 4'd1, 1, 0, 0, 4'd0, 2'b00, 0, 0, "B start"));
        table_q.push_back(mk(0, 0, 4'd2, 4'd2, 1, 0, 0, 4'd0, 2'b00, 1, 1, "B s1 fin"));
        table_q.push_back(mk(0, 0, 4'd5, 4'd0, 0, 0, 1, 4'd2, 2'b10, 1, 2, "B illegal code"));
        table_q.push_back(mk(0, 0, 4'd3, 4'd0, 0, 0, 1, 4'd2, 2'b10, 1, 2, "B error sticky"));
        table_q.push_back(mk(0, 1, 4'd0, 4'd0, 0, 0, 0, 4'd0, 2'b00, 1, 2, "B abort clears"));

        // ---- Scenario C: ignored start, finish on last allowed cycle, abort ----
        table_q.push_back(mk(1, 0, 4'd0, 4'd1, 1, 0, 0, 4'd0, 2'b00, 0, 0, "C start"));
        table_q.push_back(mk(0, 0, 4'd2, 4'd2, 1, 0, 0, 4'd0, 2'b00, 1, 1, "C s1 fin"));
        table_q.push_back(mk(1, 0, 4'd0, 4'd2, 1, 0, 0, 4'd0, 2'b00, 1, 2, "C start ignored"));
        table_q.push_back(mk(0, 0, 4'd0, 4'd2, 1, 0, 0, 4'd0, 2'b00, 1, 3, "C s2 c2"));
        table_q.push_back(mk(0, 0, 4'd3, 4'd3, 1, 0, 0, 4'd0, 2'b00, 3, 4, "C s2 fin"));
        for (int c = 1; c <= 15; c++)
            table_q.push_back(mk(0, 0, 4'd0, 4'd3, 1, 0, 0, 4'd0, 2'b00, 3, 32'(4 + c),
                                 $sformatf("C s3 c%0d", c)));
        table_q.push_back(mk(0, 0, 4'd4, 4'd4, 1, 0, 0, 4'd0, 2'b00, 16, 20, "C s3 fin on cycle 16"));
        table_q.push_back(mk(0, 1, 4'd5, 4'd0, 0, 0, 0, 4'd0, 2'b00, 16, 20, "C abort beats fin"));

        // ---- reset ----
        @(posedge clk); #1;
        check_output("reset ctrl", 64'({en_state, busy, done, error, err_stage, err_code}), 64'd0);
        check_output("reset counters", {stage_cycles, total_cycles}, 64'd0);
        rst = 1'b0;

        foreach (table_q[i]) apply_stimulus(table_q[i]);

        // ---- Watchdog: stage 3 never finishes ----
        apply_stimulus(mk(1, 0, 4'd0, 4'd1, 1, 0, 0, 4'd0, 2'b00, 0, 0, "W start"));
        apply_stimulus(mk(0, 0, 4'd2, 4'd2, 1, 0, 0, 4'd0, 2'b00, 1, 1, "W s1 fin"));
        apply_stimulus(mk(0, 0, 4'd3, 4'd3, 1, 0, 0, 4'd0, 2'b00, 1, 2, "W s2 fin"));
        for (int c = 1; c <= 15; c++)
            apply_stimulus(mk(0, 0, 4'd0, 4'd3, 1, 0, 0, 4'd0, 2'b00, 1, 32'(2 + c),
                              $sformatf("W s3 c%0d", c)));
        apply_stimulus(mk(0, 0, 4'd0, 4'd0, 0, 0, 1, 4'd3, 2'b01, 1, 18, "W timeout"));
        apply_stimulus(mk(1, 0, 4'd0, 4'd1, 1, 0, 0, 4'd0, 2'b00, 0, 0, "W restart clears"));

        // ---- ERROR exit with start+abort together goes to IDLE ----
        apply_stimulus(mk(0, 0, 4'd7, 4'd0, 0, 0, 1, 4'd1, 2'b10, 0, 1, "E illegal in s1"));
        apply_stimulus(mk(1, 1, 4'd0, 4'd0, 0, 0, 0, 4'd0, 2'b00, 0, 1, "E start+abort"));

        // ---- Reset in the middle of stage 5 ----
        apply_stimulus(mk(1, 0, 4'd0, 4'd1, 1, 0, 0, 4'd0, 2'b00, 0, 0, "R start"));
        apply_stimulus(mk(0, 0, 4'd2, 4'd2, 1, 0, 0, 4'd0, 2'b00, 1, 1, "R s1"));
        apply_stimulus(mk(0, 0, 4'd3, 4'd3, 1, 0, 0, 4'd0, 2'b00, 1, 2, "R s2"));
        apply_stimulus(mk(0, 0, 4'd4, 4'd4, 1, 0, 0, 4'd0, 2'b00, 1, 3, "R s3"));
        apply_stimulus(mk(0, 0, 4'd5, 4'd5, 1, 0, 0, 4'd0, 2'b00, 1, 4, "R s4"));
        apply_stimulus(mk(0, 0, 4'd0, 4'd5, 1, 0, 0, 4'd0, 2'b00, 1, 5, "R s5 c1"));
        #2;
        rst = 1'b1;
        #1;
        check_output("async reset ctrl", 64'({en_state, busy, done, error, err_stage, err_code}), 64'd0);
        check_output("async reset counters", {stage_cycles, total_cycles}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        apply_stimulus(mk(1, 0, 4'd0, 4'd1, 1, 0, 0, 4'd0, 2'b00, 0, 0, "P start after reset"));
        apply_stimulus(mk(0, 0, 4'd2, 4'd2, 1, 0, 0, 4'd0, 2'b00, 1, 1, "P s1 fin"));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/t05_stage_sequencer.md
# t05_stage_sequencer

Top-level controller for the team_05 Huffman compression pipeline. It sequences the stages (histogram, least-frequency sort, tree build, codebook/path generation, translation) by driving the shared `en_state` bus and advancing on each stage's `fin_state` report. Each stage runs only while `en_state` equals its stage number. The block also enforces a per-stage watchdog, flags protocol errors, and reports cycle counts for bring-up and profiling.

## Interface
- `STAGE_TIMEOUT`, default 32'd1_048_576: max cycles a stage may hold `en_state` before the watchdog fires; legal range 2..2^32-1.
- `LAST_STAGE`, default 4'd5: number of the final stage (translation); its completion code is `LAST_STAGE+1`.

Ports (reset is asynchronous, active-high):
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: request a compression run; sampled only in IDLE or ERROR.
- `abort` in 1: cancel the run; returns to IDLE without `done`.
- `fin_state` in 4: completion code from the active stage; stage k reports k+1; 0 means not finished.
- `en_state` out 4: active-stage select broadcast to all stages; 0 means none.
- `busy` out 1: high while a stage is enabled.
- `done` out 1: one-cycle pulse when the last stage completes.
- `error` out 1: sticky error flag.
- `err_stage` out 4: stage number active when the error occurred.
- `err_code` out 2: 01 = watchdog timeout, 10 = illegal `fin_state`.
- `stage_cycles` out 32: cycle count of the most recently completed stage.
- `total_cycles` out 32: cycles spent busy in the current or last run; saturates at 32'hFFFF_FFFF.

## Operation
- Reset values: `en_state`=0, `busy`=0, `done`=0, `error`=0, `err_stage`=0, `err_code`=0, `stage_cycles`=0, `total_cycles`=0. FSM enters IDLE; the internal stage counter is 0.
- **IDLE** (`en_state`=0):
  - `start`=1 and `abort`=0 → RUN with `en_state`=1 and `busy`=1.
  - Entering RUN clears the stage counter, `total_cycles` and `stage_cycles`.
- **RUN k** (`en_state`=k, 1..LAST_STAGE). Each cycle, conditions are evaluated in this priority order:
  1. `abort` → IDLE: `en_state`=0, `busy`=0, no `done`, counters hold.
  2. `fin_state` == k+1 → `stage_cycles` ← counter+1; counter ← 0. If k<LAST_STAGE, `en_state` ← k+1. If k==LAST_STAGE, go to IDLE with `en_state`=0, `busy`=0 and `done` pulsed.
  3. `fin_state` ≠ 0 and ≠ k+1 → ERROR, `err_code`=10.
  4. counter == STAGE_TIMEOUT-1 → ERROR, `err_code`=01.
  5. Otherwise counter increments.
- **ERROR** (`en_state`=0):
  - `error`=1, `busy`=0; `err_stage` = the k active when the error occurred.
  - `start`=1 clears `error`, `err_code` and `err_stage`, then begins a new run (same as IDLE start).
  - `abort` in ERROR → IDLE, with the error fields cleared.
- `start` while in RUN is ignored.
- `fin_state` is ignored in IDLE and ERROR. Stages produce `fin_state` combinationally from their gated state, so stale codes are expected outside RUN.
- `total_cycles` increments on every RUN cycle, including the completing cycle, and saturates.
- An asynchronous `rst` during any state returns immediately to the reset values; there is no drain of stage outputs.

## Timing
- All outputs are registered. `fin_state` is sampled on the rising edge, and the resulting `en_state` change is visible the next cycle.
- `start` high at edge N → `en_state`=1 after edge N.
- A stage that reports completion in its first enabled cycle yields `stage_cycles`=1. Minimum dwell per stage is 1 cycle, so the minimum full run is LAST_STAGE cycles of `busy`.
- `done` is high for exactly the cycle in which `en_state` first reads 0 after the last stage.
- Watchdog: with no completion, ERROR is entered at the edge ending the STAGE_TIMEOUT-th cycle of the stage, so `en_state`=k for exactly STAGE_TIMEOUT cycles.
- Same-edge events:
  - `abort` beats `fin_state`.
  - A matching `fin_state` beats the watchdog, so a finish on the last allowed cycle is a success.
  - `start` and `abort` together in IDLE/ERROR → IDLE.

## Test plan
- **Normal run:** reset, pulse `start`; each stage k returns `fin_state`=k+1 on its 3rd enabled cycle. Expect `en_state` to walk 1→2→3→4→5→0, each value held 3 cycles; `done` pulses once; `total_cycles`=15, `stage_cycles`=3, `error`=0.
- **Watchdog:** STAGE_TIMEOUT=16; stage 3 never finishes. Expect `en_state`=3 for 16 cycles, then `en_state`=0, `error`=1, `err_stage`=3, `err_code`=01. A following `start` clears the error and `en_state`=1.
- **Illegal code / boundary:** in stage 2, drive `fin_state`=5. Expect ERROR, `err_stage`=2, `err_code`=10. Separately, with STAGE_TIMEOUT=16, drive `fin_state`=k+1 on the 16th cycle and expect a clean advance.
- **Abort:** `abort` asserted in stage 4 in the same cycle as `fin_state`=5. Expect `en_state`=0 and `busy`=0 next cycle, no `done`, no `error`.
- **Ignored start:** pulse `start` during stage 2. Expect no restart and counters undisturbed.
- **Reset mid-run:** assert `rst` mid-stage 5 (asynchronous, between edges). Expect all outputs at reset values immediately; after release, a `start` runs normally from stage 1.
